// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with a byte FIFO,
// programmable baud divisor and a level interrupt raised when the FIFO
// has drained and the line is idle.
// Register write handshake: a register write is a single-cycle WE pulse
// qualified by Addr[3:2]. There is no back-pressure; a DATA write while the
// FIFO is full (and nothing pops that cycle) is dropped and recorded in ovf.
module uart_tx_dev #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic          ovf, en, ien;
    logic [15:0]   div;

    logic [15:0]   baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          tx_n;

    logic          we_data, we_status, we_ctrl, we_div;
    logic          empty, full, push, pop, can_pop, bit_end, busy, ien_n;
    logic [15:0]   deff_m1;
    logic          unused_bits;

    assign we_data   = WE && (Addr[3:2] == 2'd0);
    assign we_status = WE && (Addr[3:2] == 2'd1);
    assign we_ctrl   = WE && (Addr[3:2] == 2'd2);
    assign we_div    = WE && (Addr[3:2] == 2'd3);

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    // A divisor of 0 behaves like 1, so the reload value is 0 in both cases.
    assign deff_m1 = (div == 16'd0) ? 16'd0 : div - 16'd1;
    assign bit_end = (baud_cnt == 16'd0);
    // Pops only look at the registered count, so a fresh push is never bypassed.
    assign can_pop = en && !empty;
    assign pop     = can_pop && ((state == IDLE) || (state == STOP && bit_end));
    assign push    = we_data && (!full || pop);
    assign count_n = count + CW'(push) - CW'(pop);
    assign busy    = (state != IDLE);
    assign ien_n   = we_ctrl ? Din[1] : ien;

    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    // Control registers, FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            en     <= 1'b0;
            ien    <= 1'b0;
            div    <= DEFAULT_DIV;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            if (we_data && full && !pop) ovf <= 1'b1;
            else if (we_status)          ovf <= 1'b0;
            if (we_ctrl) begin
                en  <= Din[0];
                ien <= Din[1];
            end
            if (we_div) div <= Din[15:0];
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Din[7:0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // FSM next-state: each phase ends when the baud counter reaches zero.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (can_pop) state_n = START;
            START:   if (bit_end) state_n = DATA;
            DATA:    if (bit_end && bit_cnt == 3'd7) state_n = STOP;
            STOP:    if (bit_end) state_n = can_pop ? START : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: next values of the shift register, counters and tx line.
    always_comb begin
        tx_n   = tx;
        baud_n = baud_cnt;
        bit_n  = bit_cnt;
        sh_n   = shreg;
        if (pop) begin
            sh_n   = mem[rd_ptr];
            baud_n = deff_m1;
            bit_n  = 3'd0;
            tx_n   = 1'b0;
        end else begin
            case (state)
                START: begin
                    baud_n = bit_end ? deff_m1 : baud_cnt - 16'd1;
                    if (bit_end) begin
                        tx_n  = shreg[0];
                        bit_n = 3'd0;
                    end
                end
                DATA: begin
                    baud_n = bit_end ? deff_m1 : baud_cnt - 16'd1;
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            tx_n = 1'b1;
                        end else begin
                            sh_n  = shreg >> 1;
                            tx_n  = shreg[1];
                            bit_n = bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    baud_n = bit_end ? 16'd0 : baud_cnt - 16'd1;
                    tx_n   = 1'b1;
                end
                default: begin
                    tx_n = 1'b1;
                end
            endcase
        end
    end

    // Serialiser datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx       <= 1'b1;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
        end else begin
            tx       <= tx_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
        end
    end

    // Interrupt is registered from next-state values so it tracks pushes immediately.
    always_ff @(posedge clk) begin
        if (!reset) IRQ <= 1'b0;
        else        IRQ <= ien_n && (count_n == '0) && (state_n == IDLE);
    end

    // Read mux; reads are side-effect free.
    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'd1:    Dout = {16'd0, 8'(count), 4'd0, ovf, busy, full, empty};
            2'd2:    Dout = {30'd0, ien, en};
            2'd3:    Dout = {16'd0, div};
            default: Dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed bench for uart_tx_dev with a frame-decoding
// monitor that checks serial bytes against an expected-byte queue.
module tb_uart_tx_dev;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b0;
    int          mon_div = 4;

    uart_tx_dev #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .IRQ(IRQ), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] e);
        Addr = {28'd0, a};
        #1;
        chk(tag, Dout, e);
    endtask

    task automatic busy_chk(input string tag, input logic e);
        Addr = 30'd1;
        #1;
        chk(tag, {31'd0, Dout[2]}, {31'd0, e});
    endtask

    // Frame monitor: samples tx on falling edges, checks each bit is stable
    // for mon_div samples, then compares the byte with the expected queue.
    initial begin : monitor
        int         d;
        logic [9:0] bits;
        logic       ok;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                d  = mon_div;
                ok = 1'b1;
                bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < d; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (s == 0) bits[b] = tx;
                        else if (tx !== bits[b]) ok = 1'b0;
                    end
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("frame_timing", {31'd0, ok}, 32'd1);
                chk("frame_start", {31'd0, bits[0]}, 32'd0);
                chk("frame_stop", {31'd0, bits[9]}, 32'd1);
                chk("frame_data", {24'd0, bits[8:1]}, {24'd0, e});
            end
        end
    end

    initial begin : main
        logic [7:0] b;
        logic       tl [0:46];
        logic [7:0] tb_byte;
        logic       v;
        logic       quiet;

        // Reset and register defaults
        repeat (3) step();
        reset = 1'b1;
        step();
        rd(2'd0, "rst_data", 32'd0);
        rd(2'd1, "rst_status", 32'h1);
        rd(2'd2, "rst_ctrl", 32'd0);
        rd(2'd3, "rst_div", 32'd434);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);

        // Single frame 0xA5 at 4 cycles per bit
        wr(2'd3, 32'd4);
        mon_div = 4;
        wr(2'd2, 32'd1);
        mon_en = 1'b1;
        exp_q.push_back(8'hA5);
        wr(2'd0, 32'hA5);
        chk("a5_tx_e0", {31'd0, tx}, 32'd1);
        busy_chk("a5_busy_e0", 1'b0);
        step();
        chk("a5_tx_e1", {31'd0, tx}, 32'd0);
        busy_chk("a5_busy_e1", 1'b1);
        repeat (39) step();
        busy_chk("a5_busy_e40", 1'b1);
        step();
        busy_chk("a5_busy_e41", 1'b0);
        rd(2'd1, "a5_status_done", 32'h1);
        chk("a5_queue", exp_q.size(), 32'd0);

        // Overflow, ovf clear, then back-to-back drain
        wr(2'd2, 32'd0);
        wr(2'd3, 32'd2);
        mon_div = 2;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 8) exp_q.push_back(b);
            wr(2'd0, {24'd0, b});
        end
        rd(2'd1, "ovf_status", 32'h0000080A);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, "ovf_cleared", 32'h00000802);
        wr(2'd2, 32'd1);
        busy_chk("b2b_busy_e0", 1'b0);
        step();
        busy_chk("b2b_busy_e1", 1'b1);
        repeat (159) step();
        busy_chk("b2b_busy_e160", 1'b1);
        step();
        busy_chk("b2b_busy_e161", 1'b0);
        repeat (40) step();
        chk("b2b_queue", exp_q.size(), 32'd0);
        rd(2'd1, "b2b_status", 32'h1);

        // DIV=0 gives 1-cycle bits
        wr(2'd3, 32'd0);
        mon_div = 1;
        exp_q.push_back(8'h5A);
        wr(2'd0, 32'h5A);
        step();
        chk("div0_tx_e1", {31'd0, tx}, 32'd0);
        repeat (9) step();
        busy_chk("div0_busy_e10", 1'b1);
        step();
        busy_chk("div0_busy_e11", 1'b0);
        chk("div0_queue", exp_q.size(), 32'd0);

        // Interrupt timing
        wr(2'd3, 32'd2);
        mon_div = 2;
        wr(2'd2, 32'd3);
        chk("irq_idle", {31'd0, IRQ}, 32'd1);
        exp_q.push_back(8'hC3);
        wr(2'd0, 32'hC3);
        chk("irq_push_e0", {31'd0, IRQ}, 32'd0);
        repeat (20) step();
        chk("irq_e20", {31'd0, IRQ}, 32'd0);
        step();
        chk("irq_e21", {31'd0, IRQ}, 32'd1);
        wr(2'd2, 32'd1);
        chk("irq_ien_clear", {31'd0, IRQ}, 32'd0);
        chk("irq_queue", exp_q.size(), 32'd0);

        // Divisor change mid-frame, checked cycle by cycle
        mon_en = 1'b0;
        wr(2'd3, 32'd0);
        repeat (3) step();
        tb_byte = 8'h96;
        tl[0] = 1'b1;
        tl[1] = 1'b0;
        for (int i = 0; i < 4; i++) tl[2 + i] = tb_byte[i];
        for (int k = 0; k < 5; k++) begin
            v = (k < 4) ? tb_byte[4 + k] : 1'b1;
            for (int s = 0; s < 8; s++) tl[6 + 8 * k + s] = v;
        end
        tl[46] = 1'b1;
        wr(2'd0, {24'd0, tb_byte});
        chk("divchg_c0", {31'd0, tx}, {31'd0, tl[0]});
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("divchg_c%0d", c), {31'd0, tx}, {31'd0, tl[c]});
        end
        wr(2'd3, 32'd8);
        chk("divchg_c5", {31'd0, tx}, {31'd0, tl[5]});
        for (int c = 6; c <= 46; c++) begin
            step();
            chk($sformatf("divchg_c%0d", c), {31'd0, tx}, {31'd0, tl[c]});
        end
        busy_chk("divchg_idle", 1'b0);

        // Reset asserted mid-DATA aborts the frame and empties the FIFO
        wr(2'd3, 32'd4);
        wr(2'd0, 32'h3C);
        wr(2'd0, 32'hE1);
        repeat (14) step();
        busy_chk("midrst_busy_before", 1'b1);
        reset = 1'b0;
        step();
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        rd(2'd1, "midrst_status", 32'h1);
        chk("midrst_irq", {31'd0, IRQ}, 32'd0);
        rd(2'd3, "midrst_div", 32'd434);
        rd(2'd2, "midrst_ctrl", 32'd0);
        reset = 1'b1;
        wr(2'd2, 32'd1);
        quiet = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (tx !== 1'b1) quiet = 1'b0;
        end
        chk("midrst_quiet", {31'd0, quiet}, 32'd1);
        rd(2'd1, "midrst_status_end", 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
